// File: rtl/ram_bist_pkg.sv
// Shared constants and state encoding for the RAM self-test controller.
package ram_bist_pkg;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] PAT = 8'h55;

  typedef enum logic [2:0] {IDLE, W0, RW1, RW2, R3, DONE} state_t;
endpackage

// File: rtl/ram_bist_addr_gen.sv
// Up/down address counter with synchronous load and a terminal-address flag.
// last is combinational on the current count and direction; no wrap is ever requested by the controller.
module ram_bist_addr_gen
  import ram_bist_pkg::*;
#(
  parameter int N = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              step,
  input  logic              up,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_val;
    end else if (step) begin
      addr <= up ? addr + 1'b1 : addr - 1'b1;
    end
  end

  assign last = up ? (addr == ADDR_W'(N - 1)) : (addr == '0);

endmodule

// File: rtl/ram_bist.sv
// March-style BIST for a 128x8 synchronous RAM: W0(up), RW1(up), RW2(down), pipelined R3(up) + flush.
// All RAM controls are registered; read data is compared one edge after the read address was sampled.
module ram_bist #(
  parameter int DEPTH = ram_bist_pkg::DEPTH,
  parameter logic [ram_bist_pkg::DATA_W-1:0] PAT = ram_bist_pkg::PAT
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  output logic                              cs,
  output logic                              wr_e,
  output logic                              o_e,
  output logic [ram_bist_pkg::ADDR_W-1:0]   addr,
  output logic [ram_bist_pkg::DATA_W-1:0]   wdata,
  input  logic [ram_bist_pkg::DATA_W-1:0]   rdata,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic [ram_bist_pkg::ADDR_W-1:0]   fail_addr,
  output logic [ram_bist_pkg::DATA_W-1:0]   fail_data
);
  import ram_bist_pkg::*;

  state_t              state;
  logic                ph;        // RW phases: 0 = read cycle, 1 = compare/write cycle
  logic                flush;
  logic                cmp_vld;
  logic [ADDR_W-1:0]   cmp_addr;
  logic [DATA_W-1:0]   exp_dat;
  logic                ag_load, ag_step, ag_up, ag_last;
  logic [ADDR_W-1:0]   ag_val;

  assign o_e     = cs & ~wr_e;
  assign exp_dat = (state == RW2) ? ~PAT : PAT;

  ram_bist_addr_gen #(.N(DEPTH)) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ag_load),
    .load_val (ag_val),
    .step     (ag_step),
    .up       (ag_up),
    .addr     (addr),
    .last     (ag_last)
  );

  always_comb begin
    ag_load = 1'b0;
    ag_step = 1'b0;
    ag_val  = '0;
    ag_up   = (state != RW2);
    case (state)
      IDLE, DONE: ag_load = start;
      W0: begin
        ag_load = ag_last;
        ag_step = !ag_last;
      end
      RW1, RW2: begin
        if (ph && rdata == exp_dat) begin
          ag_load = ag_last;
          ag_step = !ag_last;
          ag_val  = (state == RW1) ? ADDR_W'(DEPTH - 1) : '0;
        end
      end
      R3: ag_step = !flush && !(cmp_vld && rdata != PAT) && !ag_last;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ph        <= 1'b0;
      flush     <= 1'b0;
      cmp_vld   <= 1'b0;
      cmp_addr  <= '0;
      cs        <= 1'b0;
      wr_e      <= 1'b0;
      wdata     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= W0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
            cs        <= 1'b1;
            wr_e      <= 1'b1;
            wdata     <= PAT;
          end
        end
        W0: begin
          if (ag_last) begin
            state <= RW1;
            ph    <= 1'b0;
            wr_e  <= 1'b0;
          end
        end
        RW1, RW2: begin
          if (!ph) begin
            ph    <= 1'b1;
            wr_e  <= 1'b1;
            wdata <= (state == RW1) ? ~PAT : PAT;
          end else if (rdata != exp_dat) begin
            state     <= DONE;
            cs        <= 1'b0;
            wr_e      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= 1'b0;
            fail_addr <= addr;
            fail_data <= rdata;
          end else begin
            ph   <= 1'b0;
            wr_e <= 1'b0;
            if (ag_last) begin
              state   <= (state == RW1) ? RW2 : R3;
              cmp_vld <= 1'b0;
              flush   <= 1'b0;
            end
          end
        end
        R3: begin
          // rdata here belongs to the read issued one cycle earlier (cmp_addr)
          if (cmp_vld && rdata != PAT) begin
            state     <= DONE;
            cs        <= 1'b0;
            wr_e      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= 1'b0;
            fail_addr <= cmp_addr;
            fail_data <= rdata;
          end else if (flush) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b1;
            flush <= 1'b0;
          end else begin
            cmp_vld  <= 1'b1;
            cmp_addr <= addr;
            if (ag_last) begin
              flush <= 1'b1;
              cs    <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bist.sv
// Randomized scoreboard bench for ram_bist with a behavioural RAM and fault injection.
module tb_ram_bist;
  import ram_bist_pkg::*;

  localparam logic [7:0] NPAT = ~PAT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cs, wr_e, o_e, busy, done, pass;
  logic [7:0] addr, wdata, fail_addr, fail_data;
  logic [7:0] rdata = 8'h00;

  always #5 clk = ~clk;

  ram_bist dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cs        (cs),
    .wr_e      (wr_e),
    .o_e       (o_e),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_data (fail_data)
  );

  typedef struct {
    bit ok;
    int fa;
    int fd;
    int cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Fault configuration: one stuck bit (f_addr/f_bit/f_val) or an address reading 0 in the last read pass
  int   f_addr = -1, f_bit = 0, f_val = 0, r3_addr = -1;
  bit   clr_req = 1'b0;
  logic [7:0] mem [128];
  int   wcnt [128];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] stuck(input int a, input logic [7:0] d);
    logic [7:0] r;
    r = d;
    if (a == f_addr) r[f_bit] = f_val[0];
    return r;
  endfunction

  // Behavioural RAM: write on cs&wr_e, read data valid after the sampling edge
  always @(posedge clk) begin
    if (clr_req) foreach (wcnt[i]) wcnt[i] <= 0;
    if (cs) begin
      if (wr_e) begin
        mem[addr[6:0]]  <= stuck(int'(addr), wdata);
        wcnt[addr[6:0]] <= wcnt[addr[6:0]] + 1;
      end else if (int'(addr) == r3_addr && wcnt[addr[6:0]] >= 3) begin
        rdata <= 8'h00;
      end else begin
        rdata <= mem[addr[6:0]];
      end
    end
  end

  // Reference: walk the four march phases over an array and count busy cycles
  function automatic exp_t ref_run();
    logic [7:0] m [128];
    logic [7:0] v;
    exp_t e;
    int cyc;
    cyc = 0;
    e.ok = 1'b1; e.fa = 0; e.fd = 0; e.cyc = 769;
    for (int a = 0; a < 128; a++) begin
      m[a] = stuck(a, PAT);
      cyc++;
    end
    for (int a = 0; a < 128; a++) begin
      cyc += 2;
      v = m[a];
      m[a] = stuck(a, NPAT);
      if (v !== PAT) begin
        e.ok = 1'b0; e.fa = a; e.fd = int'(v); e.cyc = cyc;
        return e;
      end
    end
    for (int a = 127; a >= 0; a--) begin
      cyc += 2;
      v = m[a];
      m[a] = stuck(a, PAT);
      if (v !== NPAT) begin
        e.ok = 1'b0; e.fa = a; e.fd = int'(v); e.cyc = cyc;
        return e;
      end
    end
    for (int a = 0; a < 128; a++) begin
      v = (a == r3_addr) ? 8'h00 : m[a];
      if (v !== PAT) begin
        e.ok = 1'b0; e.fa = a; e.fd = int'(v); e.cyc = 640 + a + 2;
        return e;
      end
    end
    return e;
  endfunction

  // Monitor: tracks busy cycles and RAM accesses, checks each completed run against the scoreboard
  bit         busy_q = 1'b0, done_q = 1'b0;
  int         bcnt = 0, acc = 0, pend = 0, cur_acc = 0;
  logic [7:0] tr_a [1024];
  bit         tr_w [1024];
  int         wc [128];
  exp_t       cur;

  always @(negedge clk) begin
    int bad;
    if (busy && !busy_q) begin
      bcnt = 0;
      acc  = 0;
    end
    if (busy) bcnt++;
    if (cs) begin
      if (acc < 1024) begin
        tr_a[acc] = addr;
        tr_w[acc] = wr_e;
      end
      acc++;
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0) chk("access_count", acc, cur_acc);
    end
    if (done && !done_q) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done rose with no run outstanding");
      end else begin
        cur = sb_q.pop_front();
        chk("pass", pass, cur.ok);
        chk("fail_addr", fail_addr, cur.fa);
        chk("fail_data", fail_data, cur.fd);
        chk("busy_cycles", bcnt, cur.cyc);
        chk("busy_low_at_done", busy, 0);
        cur_acc = (cur.cyc == 769) ? 768 : cur.cyc;
        pend = 4;
        if (cur.ok) begin
          foreach (wc[i]) wc[i] = 0;
          bad = 0;
          for (int i = 0; i < 768 && i < acc; i++) begin
            if (tr_a[i][7]) bad++;
            if (tr_w[i]) wc[tr_a[i][6:0]]++;
          end
          foreach (wc[i]) if (wc[i] != 3) bad++;
          chk("writes_per_addr", bad, 0);
          bad = 0;
          for (int k = 0; k < 256; k++) begin
            if (int'(tr_a[384+k]) != 127 - k/2) bad++;
            if (tr_w[384+k] != k[0]) bad++;
          end
          chk("rw2_addr_order", bad, 0);
        end
      end
    end
    busy_q = busy;
    done_q = done;
  end

  task automatic set_fault(input int fa, input int fb, input int fv, input int ra);
    f_addr = fa; f_bit = fb; f_val = fv; r3_addr = ra;
  endtask

  task automatic do_run(input int glitch_at);
    exp_t e;
    int n;
    e = ref_run();
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b1; clr_req = 1'b1;
    @(negedge clk);
    start = 1'b0; clr_req = 1'b0;
    if (glitch_at > 0 && glitch_at + 5 < e.cyc) begin
      repeat (glitch_at - 1) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: done=%0d after %0d cycles, required 1", done, n);
    end
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int n;
    #12;
    chk("reset_outputs", {cs, wr_e, o_e, addr, wdata, busy, done, pass, fail_addr, fail_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_quiet", {cs, busy, done}, 0);

    // Fault-free run with a start pulse at cycle 300 that must be ignored
    set_fault(-1, 0, 0, -1);
    do_run(300);

    // Bit 0 of 0x2A stuck at 1: caught in RW2
    set_fault(8'h2A, 0, 1, -1);
    do_run(0);
    chk("stuck_fail_addr", fail_addr, 8'h2A);
    chk("stuck_fail_data", fail_data, 8'hAB);

    // 0x7F reads 0 only in the final pass: caught by the flush compare
    set_fault(-1, 0, 0, 8'h7F);
    do_run(0);
    chk("flush_fail_addr", fail_addr, 8'h7F);
    chk("flush_fail_data", fail_data, 8'h00);

    // Asynchronous reset mid-run
    set_fault(-1, 0, 0, -1);
    @(negedge clk);
    start = 1'b1; clr_req = 1'b1;
    @(negedge clk);
    start = 1'b0; clr_req = 1'b0;
    repeat (399) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", {cs, wr_e, o_e, addr, wdata, busy, done, pass, fail_addr, fail_data}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (cs || busy || done) n++;
    end
    chk("idle_after_reset", n, 0);

    // Randomized back-to-back runs, each restarting from DONE
    for (int r = 0; r < 6; r++) begin
      case ($urandom_range(0, 2))
        0: set_fault(-1, 0, 0, -1);
        1: set_fault(int'($urandom_range(0, 127)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 1)), -1);
        default: set_fault(-1, 0, 0, int'($urandom_range(0, 127)));
      endcase
      do_run($urandom_range(0, 1) ? int'($urandom_range(10, 760)) : 0);
    end

    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_bist.md
RAM_BIST -- requirements
Module: ram_bist

Built-in self-test controller that sits directly upstream of the team's 128x8 single-port synchronous RAM. It drives the RAM's chip-select, write-enable, output-enable, address and write data, and checks the read data. Read latency of the RAM: an address sampled on edge N with cs=1 and wr_e=0 yields its data on rdata after edge N, and the data is sampled by this block on edge N+1.

Interface
Parameters:
REQ-001 DEPTH, 128, number of RAM words tested (addresses 0..DEPTH-1).
REQ-002 PAT, 8'h55, base test pattern; ~PAT (8'hAA) is the complement pattern.
Ports:
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  level-sampled request to begin a test run.
REQ-006 cs  out  1  RAM chip select.
REQ-007 wr_e  out  1  RAM write enable (1 = write, 0 = read).
REQ-008 o_e  out  1  RAM output enable; equals cs AND NOT wr_e.
REQ-009 addr  out  8  RAM address; bit 7 is always 0.
REQ-010 wdata  out  8  RAM write data.
REQ-011 rdata  in  8  RAM read data.
REQ-012 busy  out  1  test run in progress.
REQ-013 done  out  1  test run finished; sticky until the next accepted start.
REQ-014 pass  out  1  valid while done=1; 1 = no mismatch.
REQ-015 fail_addr  out  8  address of the first mismatch; valid while done=1 and pass=0.
REQ-016 fail_data  out  8  read value at the first mismatch; valid while done=1 and pass=0.

Function
REQ-017 The block SHALL have the states IDLE, W0, RW1, RW2, R3 and DONE.
REQ-018 IDLE/DONE -> W0 when start=1 is sampled; that edge sets busy=1 and clears done, pass, fail_addr and fail_data.
REQ-019 start SHALL be ignored while busy=1.
REQ-020 W0 (one cycle per address, ascending 0..127): write PAT to each address (cs=1, wr_e=1); after address 127, go to RW1.
REQ-021 RW1 (ascending): for each address, spend two cycles.
- Cycle a: read (cs=1, wr_e=0).
- Cycle b: compare rdata with PAT and write ~PAT to the same address.
- After address 127, go to RW2.
REQ-022 RW2 (descending 127..0): same two-cycle read/compare/write sequence, expecting ~PAT and writing PAT. After address 0, go to R3.
REQ-023 R3 (ascending, pipelined): one read per cycle for addresses 0..127, with each read compared one cycle later. It is followed by one flush cycle (cs=0) that compares address 127; then go to DONE.
REQ-024 A fault-free run SHALL keep busy=1 for exactly 769 cycles (128+256+256+129).
REQ-025 On the first mismatch the block SHALL:
- capture fail_addr and fail_data;
- set pass=0 and done=1, busy=0;
- go to DONE on the compare edge;
- issue no further RAM access.
REQ-026 On normal completion, busy falls and done=1, pass=1 rise on the same edge.
REQ-027 cs=0, wr_e=0, o_e=0 SHALL hold in IDLE, in DONE and during the R3 flush cycle.
REQ-028 The address counter SHALL NOT wrap: the terminal address (127 ascending, 0 descending) ends the phase.
REQ-029 A start sampled in DONE SHALL restart the run from W0, with the same behaviour as from IDLE.

Reset
REQ-030 While rst_n=0, all outputs are 0 (cs, wr_e, o_e, addr, wdata, busy, done, pass, fail_addr, fail_data) and the state is IDLE, independent of clk.
REQ-031 Reset asserted mid-run SHALL abort the run immediately, with no further RAM access; after release the block waits in IDLE for start.

Structure
REQ-032 Package ram_bist_pkg SHALL hold DEPTH, ADDR_W=8, DATA_W=8, PAT and the state enum.
REQ-033 Sub-module ram_bist_addr_gen SHALL provide an up/down address counter with load, step and a last-address flag; all else stays in ram_bist.

Verification
REQ-034 Fault-free RAM model, start pulse -> busy for 769 cycles, then done=1, pass=1, and each address 0..127 written exactly 3 times.
REQ-035 Bit 0 of address 0x2A stuck at 1 -> fail in RW2 with fail_addr=0x2A, fail_data=0xAB, pass=0, and no accesses after the compare.
REQ-036 Address bus monitor during RW2 -> addresses 0x7F down to 0x00, each held for 2 cycles as a read then a write.
REQ-037 start pulsed at cycle 300 of a run -> no effect; completion still at cycle 769.
REQ-038 rst_n driven low at cycle 400 -> all outputs 0 asynchronously; after release, cs stays 0 until start.
REQ-039 Address 0x7F reads 0x00 only in R3 -> fail via the flush cycle with fail_addr=0x7F, fail_data=0x00.
